// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
package div_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

   function automatic int CNT_W(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/zero_check.sv
// Combinational all-zero detector with both polarities.
module zero_check #(
   parameter int N = 32
) (
   input  logic [N-1:0] value,
   output logic         zero,
   output logic         nzero
);

   assign zero  = ~|value;
   assign nzero = |value;

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// valid/ready on both request and result sides.
module iter_divider
   import div_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic         signed_op,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero,
   output logic         busy
);

   localparam int CW = CNT_W(N);

   div_state_t    state;
   logic [N-1:0]  rem;
   logic [N-1:0]  quo;
   logic [N-1:0]  dmag;
   logic [CW-1:0] count;
   logic          q_neg;
   logic          r_neg;
   logic          divisor_zero;

   logic [N:0]    rsh;
   logic [N:0]    trial;
   logic [N-1:0]  rem_nxt;
   logic [N-1:0]  quo_nxt;

   function automatic logic [N-1:0] mag(input logic signed [N-1:0] v, input logic s);
      return (s && v[N-1]) ? -v : v;
   endfunction

   function automatic logic [N-1:0] neg_if(input logic signed [N-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   zero_check #(.N(N)) u_zero_check (
      .value (divisor),
      .zero  (divisor_zero),
      .nzero ()
   );

   // The partial remainder stays below dmag, so N+1 bits hold both the
   // shifted value and the signed trial difference without overflow.
   always_comb begin
      rsh   = {rem, quo[N-1]};
      trial = rsh - {1'b0, dmag};
      if (!trial[N]) begin
         rem_nxt = trial[N-1:0];
         quo_nxt = {quo[N-2:0], 1'b1};
      end else begin
         rem_nxt = rsh[N-1:0];
         quo_nxt = {quo[N-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         start_ready <= 1'b1;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         rem         <= '0;
         quo         <= '0;
         dmag        <= '0;
         count       <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  q_neg       <= signed_op & (dividend[N-1] ^ divisor[N-1]);
                  r_neg       <= signed_op & dividend[N-1];
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
                  if (divisor_zero) begin
                     state       <= DONE;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     res_valid   <= 1'b1;
                  end else begin
                     state       <= CALC;
                     rem         <= '0;
                     quo         <= mag(dividend, signed_op);
                     dmag        <= mag(divisor, signed_op);
                     count       <= CW'(N);
                     div_by_zero <= 1'b0;
                  end
               end
            end
            CALC: begin
               rem   <= rem_nxt;
               quo   <= quo_nxt;
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  state     <= DONE;
                  res_valid <= 1'b1;
                  quotient  <= neg_if(quo_nxt, q_neg);
                  remainder <= neg_if(rem_nxt, r_neg);
               end
            end
            DONE: begin
               if (res_ready) begin
                  state       <= IDLE;
                  res_valid   <= 1'b0;
                  start_ready <= 1'b1;
                  busy        <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: directed corner cases plus random operations.
module tb_iter_divider;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_valid;
   logic         start_ready;
   logic         signed_op;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         res_valid;
   logic         res_ready = 1'b1;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;
   logic         busy;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
      int           acc;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   force_low = 1'b0;
   bit   bp_random = 1'b0;
   bit   shown = 1'b0;

   iter_divider #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer division, which truncates toward zero and gives
   // the remainder the dividend's sign; MIN/-1 wraps to MIN in N bits.
   function automatic exp_t model(input bit s, input logic [N-1:0] a, input logic [N-1:0] b,
                                  input int acc);
      exp_t   e;
      longint sa;
      longint sb;
      e.acc = acc;
      if (b == '0) begin
         e.q  = '1;
         e.r  = a;
         e.dz = 1'b1;
      end else if (!s) begin
         e.q  = a / b;
         e.r  = a % b;
         e.dz = 1'b0;
      end else begin
         sa   = longint'($signed(a));
         sb   = longint'($signed(b));
         e.q  = N'(sa / sb);
         e.r  = N'(sa % sb);
         e.dz = 1'b0;
      end
      return e;
   endfunction

   always @(posedge clk) begin
      #2;
      res_ready = force_low ? 1'b0 : (bp_random ? 1'($urandom_range(0, 1)) : 1'b1);
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         shown = 1'b0;
      end else if (res_valid) begin
         if (!shown) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got q=%h r=%h with nothing outstanding",
                        quotient, remainder);
            end else begin
               cur = exp_q.pop_front();
               chk("quotient", 64'(quotient), 64'(cur.q));
               chk("remainder", 64'(remainder), 64'(cur.r));
               chk("div_by_zero", 64'(div_by_zero), 64'(cur.dz));
               chk("latency", 64'(cyc + 1 - cur.acc),
                   64'(cur.dz ? 1 : N + 1));
            end
            shown = 1'b1;
         end else begin
            chk("hold_quotient", 64'(quotient), 64'(cur.q));
            chk("hold_remainder", 64'(remainder), 64'(cur.r));
         end
         if (res_ready) shown = 1'b0;
      end
   end

   task automatic issue(input bit s, input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
      int n = 0;
      @(negedge clk);
      while (!start_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!start_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: start_ready=%b required 1", start_ready);
         return;
      end
      signed_op   = s;
      dividend    = a;
      divisor     = b;
      start_valid = 1'b1;
      if (push) exp_q.push_back(model(s, a, b, cyc + 1));
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      dividend    = $urandom;
      divisor     = $urandom;
      signed_op   = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || res_valid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || res_valid) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: outstanding=%0d res_valid=%b required 0/0",
                  exp_q.size(), res_valid);
      end
   endtask

   initial begin
      int           n;
      int           sel;
      logic [N-1:0] a;
      logic [N-1:0] b;

      start_valid = 1'b0;
      signed_op   = 1'b0;
      dividend    = '0;
      divisor     = '0;

      repeat (3) @(negedge clk);
      chk("rst_start_ready", 64'(start_ready), 64'(1));
      chk("rst_res_valid", 64'(res_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_quotient", 64'(quotient), 64'(0));
      chk("rst_remainder", 64'(remainder), 64'(0));
      chk("rst_div_by_zero", 64'(div_by_zero), 64'(0));
      rst_n = 1'b1;

      issue(1'b0, 32'd100, 32'd7, 1'b1);
      issue(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1);
      issue(1'b1, 32'd100, 32'hFFFFFFF9, 1'b1);
      issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      issue(1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      issue(1'b0, 32'h00001234, 32'h0, 1'b1);
      issue(1'b1, 32'h00001234, 32'h0, 1'b1);
      drain();

      // Backpressure: result held in DONE, an incoming request is ignored.
      force_low = 1'b1;
      issue(1'b1, 32'd1000, 32'hFFFFFFFD, 1'b1);
      n = 0;
      while (!res_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_res_valid", 64'(res_valid), 64'(1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_start_ready", 64'(start_ready), 64'(0));
         chk("bp_busy", 64'(busy), 64'(1));
         chk("bp_res_valid_held", 64'(res_valid), 64'(1));
         start_valid = (i == 1);
         dividend    = $urandom;
         divisor     = $urandom;
      end
      start_valid = 1'b0;
      force_low   = 1'b0;
      n = 0;
      while (!start_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("bp_release_ready", 64'(start_ready), 64'(1));
      chk("bp_release_valid", 64'(res_valid), 64'(0));
      issue(1'b0, 32'd77, 32'd5, 1'b1);
      drain();

      // Reset in the middle of an iteration aborts it without a result.
      issue(1'b0, 32'hDEADBEEF, 32'd3, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_res_valid", 64'(res_valid), 64'(0));
      chk("abort_quotient", 64'(quotient), 64'(0));
      chk("abort_remainder", 64'(remainder), 64'(0));
      chk("abort_start_ready", 64'(start_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      issue(1'b0, 32'hFFFFFFFF, 32'h10, 1'b1);
      drain();

      bp_random = 1'b1;
      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 7));
         case (sel)
            0:       b = '0;
            1:       b = '1;
            2:       b = N'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         a = (sel == 3 || sel == 1) ? ((i % 2 == 0) ? 32'h80000000 : $urandom) : $urandom;
         issue(1'($urandom_range(0, 1)), a, b, 1'b1);
      end
      drain();
      bp_random = 1'b0;

      chk("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
Multi-cycle restoring divider for the MIPS EX stage, serving DIV/DIVU and writing the HI/LO pair.
- Accepts one operation through a valid/ready handshake and iterates one quotient bit per cycle.
- Presents quotient and remainder through a second valid/ready handshake.
- Uses the existing zero_check block on the divisor to detect divide-by-zero and bypass iteration.

Parameters:
N, 32, operand/result width in bits (N >= 2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operation request
start_ready  output  1  divider can accept a request
signed_op  input  1  1 = DIV (two's complement), 0 = DIVU
dividend  input  N  numerator
divisor  input  N  denominator
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
quotient  output  N  quotient (to LO)
remainder  output  N  remainder (to HI)
div_by_zero  output  1  result came from a zero divisor
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, start_ready=1, res_valid=0, busy=0.
  - quotient, remainder and div_by_zero = 0.
  - Internal accumulators and counter are cleared.
  - Reset asserted mid-CALC or in DONE aborts the operation; no result is ever presented.
- States: IDLE, CALC, DONE.
- start_ready = (state==IDLE). A transfer occurs on start_valid && start_ready at a rising edge; inputs are sampled only on that edge.
- IDLE, on accept:
  - Latch |dividend| and |divisor|. Magnitudes apply only when signed_op=1; otherwise use the raw values.
  - Latch q_neg = signed_op & (dividend[N-1]^divisor[N-1]) and r_neg = signed_op & dividend[N-1].
  - A zero_check instance runs on the unlatched divisor input. If zero=1: go to DONE with quotient='1 (all ones), remainder=dividend (raw), div_by_zero=1.
  - Otherwise go to CALC with count=N and div_by_zero=0.
- CALC, each cycle (restoring step):
  - Shift {rem, quo} left by one.
  - Compute trial = rem - divisor_mag in N+1 bits.
  - If trial is non-negative: rem=trial and quo LSB=1. Otherwise quo LSB=0.
  - Decrement count. When count reaches 0 after the step, go to DONE.
  - On the DONE transition, apply the sign fix: quotient = q_neg ? -quo : quo, remainder = r_neg ? -rem : rem.
- Latency: a non-zero divisor gives res_valid exactly N+1 cycles after the accepting edge. A zero divisor gives res_valid 1 cycle after it.
- DONE:
  - res_valid=1. Outputs are held stable while res_ready=0.
  - On res_valid && res_ready, go to IDLE; res_valid drops the next cycle.
  - No new request is accepted in the same cycle (start_ready=0 in DONE).
  - quotient and remainder keep their values after leaving DONE until the next result.
- Signed overflow (dividend=MIN_INT, divisor=-1):
  - The magnitude path yields quo=2^(N-1); negation is not applied because q_neg=0.
  - Required result: quotient=MIN_INT, remainder=0, with no special case.
- Remainder sign follows the dividend; quotient truncates toward zero.
- start_valid asserted outside IDLE is ignored; inputs may change freely.

Decomposition:
- Package div_pkg holds:
  - the state enum type div_state_t {IDLE, CALC, DONE};
  - a function CNT_W(N) = $clog2(N)+1 for the counter width.
- One sub-module: zero_check #(.N(N)) on the divisor. Use its zero output; nzero is unused.
- Sign fix (conditional two's-complement negate) stays inline; it is not a separate module.

Test Plan:
- DIVU 100/7 (signed_op=0) -> after 33 cycles: quotient=14, remainder=2, div_by_zero=0, res_valid=1.
- DIV -100/7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE). Repeat with 100/-7 -> quotient=-14, remainder=2.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Repeat as DIVU -> quotient=0, remainder=0x80000000.
- Divisor 0, dividend 0x1234 -> res_valid 1 cycle after accept: quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> outputs stable, start_ready=0, and a start_valid pulse in that window is ignored. With res_ready=1 -> IDLE next cycle, after which a new request is accepted.
- Pull rst_n low at CALC cycle 10 -> immediately: busy=0, res_valid=0, quotient=0, remainder=0, start_ready=1. A fresh 0xFFFFFFFF/0x10 DIVU then gives quotient=0x0FFFFFFF, remainder=0xF.
